hpc3_rnd_feeder: RTL and testbench

Fresh-randomness source for a bank of masked HPC3 AND gadgets. Sits directly upstream of the gadgets and drives their `rnd` buses. Expands a seed into one fresh `hpc3rnd`-bit word per gadget per enabled cycle, using a bank of 64-bit Galois LFSR lanes. Has a seed handshake, a fixed warm-up phase, and a valid/ready output handshake that follows the stalls of the gadget pipeline.

---
 rtl/hpc3_rnd_feeder_pkg.sv | 10 +
 rtl/hpc3_rnd_feeder_if.sv | 12 +
 rtl/hpc3_rnd_feeder_lane.sv | 14 +
 rtl/hpc3_rnd_feeder.sv | 75 +++++++
 tb/tb_hpc3_rnd_feeder.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/hpc3_rnd_feeder_pkg.sv
// hpc3_rnd_pkg: shared FSM states, LFSR tap and sizing helpers for hpc3_rnd_feeder
package hpc3_rnd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN} state_t;
  localparam logic [63:0] LFSR_TAP = 64'hD800000000000000;
  localparam int DEFAULTSHARES = 2;
  localparam int DEFAULT_WARMUP = 128;
  function automatic int hpc3rnd_bits(input int shares);
    return shares * (shares - 1);
  endfunction
endpackage

// File: rtl/hpc3_rnd_feeder_if.sv
// hpc3_rnd_feeder_if: seed handshake and randomness stream between feeder and gadget bank
interface hpc3_rnd_feeder_if #(parameter int RW = 8);
  logic [63:0]   seed_in;
  logic          seed_valid;
  logic          seed_ready;
  logic [RW-1:0] rnd_out;
  logic          rnd_valid;
  logic          rnd_ready;
  logic          reseed_req;
  modport master (input seed_in, seed_valid, rnd_ready, output seed_ready, rnd_out, rnd_valid, reseed_req);
  modport slave (output seed_in, seed_valid, rnd_ready, input seed_ready, rnd_out, rnd_valid, reseed_req);
endinterface

// File: rtl/hpc3_rnd_feeder_lane.sv
// lfsr64_lane: one 64-bit Galois LFSR (x^64+x^63+x^61+x^60+1), load beats step
module lfsr64_lane
  import hpc3_rnd_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic [63:0] load_val,
  input  logic        step,
  output logic [63:0] state
);
  // load a new value, advance one Galois step, or hold
  always_ff @(posedge clk)
    state <= load ? load_val : step ? (state >> 1) ^ (state[0] ? LFSR_TAP : 64'd0) : state;
endmodule

// File: rtl/hpc3_rnd_feeder.sv
// hpc3_rnd_feeder: seeded LFSR bank driving HPC3 gadget rnd buses; optional HPC3_RND_REFRESH_EN adds reseed_req
module hpc3_rnd_feeder
  import hpc3_rnd_pkg::*;
#(
  parameter int d = DEFAULTSHARES,
  parameter int N_GADGETS = 4,
  parameter int WARMUP = DEFAULT_WARMUP,
  parameter int RESEED_PERIOD = 1024
) (
  input logic clk,
  input logic syncrst,
  hpc3_rnd_feeder_if.master bus
);
  localparam int hpc3rnd = hpc3rnd_bits(d);
  localparam int RW = N_GADGETS * hpc3rnd;
  localparam int CW = $clog2(WARMUP + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic seed_hs, step, load;
  logic [RW-1:0] lsb;
  assign bus.seed_ready = state != ST_WARMUP;
  assign bus.rnd_valid = state == ST_RUN;
  assign seed_hs = bus.seed_valid & bus.seed_ready;
  assign load = syncrst | seed_hs;
  assign bus.rnd_out = lsb;
  // state and warm-up counter registers
  always_ff @(posedge clk)
    if (syncrst) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // seed load restarts warm-up; warm-up steps freely; run steps only on consumption
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    step = 1'b0;
    if (seed_hs) begin
      state_nx = ST_WARMUP;
      cnt_nx = '0;
    end else if (state == ST_WARMUP) begin
      step = 1'b1;
      state_nx = cnt == CW'(WARMUP - 1) ? ST_RUN : ST_WARMUP;
      cnt_nx = cnt == CW'(WARMUP - 1) ? cnt : cnt + 1'b1;
    end else if (state == ST_RUN) begin
      step = bus.rnd_ready;
    end
  end
  for (genvar k = 0; k < RW; k++) begin : g_lane
    logic [63:0] s;
    wire unused_hi = &{1'b0, s[63:1]};
    lfsr64_lane u_lane (
      .clk,
      .load,
      .load_val(syncrst ? 64'd0 : {1'b1, bus.seed_in[62:0] ^ 63'(k)}),
      .step,
      .state(s)
    );
    assign lsb[k] = s[0];
  end
`ifdef HPC3_RND_REFRESH_EN
  localparam int UW = $clog2(RESEED_PERIOD + 1);
  logic [UW-1:0] use_cnt;
  // consumed-word count since the last seed load, saturating at the period
  always_ff @(posedge clk)
    if (syncrst || seed_hs) use_cnt <= '0;
    else if (bus.rnd_valid && bus.rnd_ready && use_cnt != UW'(RESEED_PERIOD)) use_cnt <= use_cnt + 1'b1;
  assign bus.reseed_req = use_cnt == UW'(RESEED_PERIOD);
`else
  localparam int unused_period = RESEED_PERIOD;
  assign bus.reseed_req = 1'b0;
`endif
endmodule

// File: tb/tb_hpc3_rnd_feeder.sv
// tb_hpc3_rnd_feeder: directed self-checking bench for hpc3_rnd_feeder
module tb_hpc3_rnd_feeder;
  localparam logic [63:0] TAP = 64'hD800000000000000;
  logic clk = 0, syncrst;
  int tests = 0, fails = 0;
  logic [63:0] ml [8];
  hpc3_rnd_feeder_if #(.RW(8)) bus ();
  hpc3_rnd_feeder #(.d(2), .N_GADGETS(4), .WARMUP(128), .RESEED_PERIOD(8)) dut (
    .clk(clk), .syncrst(syncrst), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mload(input logic [63:0] sd);
    for (int k = 0; k < 8; k++) ml[k] = {1'b1, sd[62:0] ^ 63'(k)};
  endtask

  task automatic madv(input int n);
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) ml[k] = ml[k][0] ? (ml[k] >> 1) ^ TAP : ml[k] >> 1;
  endtask

  function automatic logic [63:0] exp_out();
    logic [63:0] r = '0;
    for (int k = 0; k < 8; k++) r[k] = ml[k][0];
    return r;
  endfunction

  task automatic seed(input logic [63:0] sd);
    bus.seed_in = sd;
    bus.seed_valid = 1;
    tick();
    bus.seed_valid = 0;
    mload(sd);
  endtask

  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    syncrst = 1;
    bus.seed_in = '0;
    bus.seed_valid = 0;
    bus.rnd_ready = 0;
    repeat (2) tick();
    syncrst = 0;
    chk("rst_seed_ready", 64'(bus.seed_ready), 1);
    chk("rst_rnd_valid", 64'(bus.rnd_valid), 0);
    chk("rst_rnd_out", 64'(bus.rnd_out), 0);
    chk("rst_reseed_req", 64'(bus.reseed_req), 0);
    seed(64'h0);
    for (int i = 0; i < 128; i++) begin
      chk("warm_seed_ready", 64'(bus.seed_ready), 0);
      chk("warm_rnd_valid", 64'(bus.rnd_valid), 0);
      tick();
    end
    madv(128);
    chk("run_rnd_valid", 64'(bus.rnd_valid), 1);
    chk("run_seed_ready", 64'(bus.seed_ready), 1);
    chk("run_first_word", 64'(bus.rnd_out), exp_out());
    for (int i = 0; i < 4; i++) begin
      bus.rnd_ready = pat[i];
      tick();
      if (pat[i]) madv(1);
      chk("ready_pattern_word", 64'(bus.rnd_out), exp_out());
    end
    for (int i = 0; i < 24; i++) begin
      bus.rnd_ready = 1'($urandom_range(0, 1));
      tick();
      if (bus.rnd_ready) madv(1);
      chk("ready_random_word", 64'(bus.rnd_out), exp_out());
      chk("ready_random_valid", 64'(bus.rnd_valid), 1);
    end
    bus.rnd_ready = 1;
    seed(64'h1234);
    bus.rnd_ready = 0;
    for (int i = 0; i < 128; i++) begin
      chk("reseed_rnd_valid_low", 64'(bus.rnd_valid), 0);
      tick();
    end
    madv(128);
    chk("reseed_rnd_valid_high", 64'(bus.rnd_valid), 1);
    chk("reseed_first_word", 64'(bus.rnd_out), exp_out());
    bus.rnd_ready = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      madv(1);
      chk("reseed_stream", 64'(bus.rnd_out), exp_out());
    end
    bus.rnd_ready = 0;
    seed(64'hABCD);
    repeat (60) tick();
    syncrst = 1;
    tick();
    syncrst = 0;
    chk("midrst_seed_ready", 64'(bus.seed_ready), 1);
    chk("midrst_rnd_valid", 64'(bus.rnd_valid), 0);
    chk("midrst_rnd_out", 64'(bus.rnd_out), 0);
    chk("midrst_reseed_req", 64'(bus.reseed_req), 0);
    for (int i = 0; i < 200; i++) begin
      chk("idle_rnd_valid", 64'(bus.rnd_valid), 0);
      tick();
    end
    seed(64'hFEED);
    repeat (128) tick();
    madv(128);
    chk("refresh_first_word", 64'(bus.rnd_out), exp_out());
    bus.rnd_ready = 1;
`ifdef HPC3_RND_REFRESH_EN
    for (int i = 0; i < 8; i++) begin
      chk("refresh_req_early", 64'(bus.reseed_req), 0);
      tick();
      madv(1);
    end
    chk("refresh_req_rise", 64'(bus.reseed_req), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      madv(1);
      chk("refresh_req_hold", 64'(bus.reseed_req), 1);
      chk("refresh_keeps_valid", 64'(bus.rnd_valid), 1);
      chk("refresh_stream", 64'(bus.rnd_out), exp_out());
    end
    bus.rnd_ready = 0;
    seed(64'h55);
    chk("refresh_req_clear", 64'(bus.reseed_req), 0);
`else
    for (int i = 0; i < 2000; i++) begin
      chk("noref_req_low", 64'(bus.reseed_req), 0);
      tick();
      madv(1);
    end
    chk("noref_stream", 64'(bus.rnd_out), exp_out());
    chk("noref_req_end", 64'(bus.reseed_req), 0);
`endif
    bus.rnd_ready = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
